ahb_sram_ctrl: RTL and testbench
================================

# ahb_sram_ctrl

Parametrised AHB-Lite slave that fronts a multi-bank, byte-laned single-port SRAM array and supersedes the fixed 32-bit, two-bank, zero-wait SRAM bridge. Data width, address space, bank count and SRAM read latency are parameters. Adds wait-state insertion on reads and a two-cycle AHB ERROR response for illegal transfers. Sits between the AHB interconnect and the SRAM macros.

## Interface
- DATA_W, 32: AHB/SRAM data width; 32 or 64.
- ADDR_W, 16: byte-address bits decoded; memory size 2^ADDR_W bytes.
- NBANK, 2: number of banks; power of two, 1..8.
- RD_WAIT, 0: extra SRAM read-latency cycles; 0..3.
- Derived: LANES=DATA_W/8, BB=log2(NBANK), LB=log2(LANES), SA_W=ADDR_W-BB-LB.
- hclk  in  1  clock, rising edge.
- hrstn  in  1  asynchronous, active-low reset.
- hsel, hready_in  in  1 each  AHB select / bus ready.
- htrans  in  2; hsize  in  3; hburst  in  3; hwrite  in  1  AHB control.
- haddr  in  32  byte address.
- hwdata  in  DATA_W  write data, data phase.
- hready_out  out  1  slave ready; reset 1.
- hresp  out  1  0=OKAY, 1=ERROR; reset 0.
- hrdata  out  DATA_W  read data; reset 0.
- bank_csn  out  NBANK*LANES  active-low byte chip selects, bank b lane l at bit b*LANES+l; reset all 1.
- sram_we  out  1  write enable, shared; reset 0.
- sram_addr  out  SA_W  word address, shared; reset 0.
- sram_wdata  out  DATA_W  = hwdata (combinational).
- sram_q  in  NBANK*LANES*8  read data, bank b at [b*DATA_W +: DATA_W].

## Operation
- Accept: hsel && hready_in && htrans[1] (NONSEQ/SEQ) registers haddr, hsize, hwrite. IDLE/BUSY or unselected: nothing registered; zero-wait OKAY.
- hburst ignored; each beat is an independent single with its own address.
- Decode (registered address): bank = addr[ADDR_W-1 -: BB]; sram_addr = addr[ADDR_W-BB-1 : LB]; lanes: hsize=LB all lanes, smaller sizes 2^hsize lanes starting at addr[LB-1:0]. Non-selected banks all-ones.
- FSM states: IDLE, WR, RD, ERR1, ERR2.
  - IDLE: accept write -> WR; accept read -> RD; illegal accept -> ERR1.
  - WR: one cycle; csn/we=1 asserted, hready_out=1; next per accept rule.
  - RD: RD_WAIT+1 cycles; csn/addr held, we=0; hready_out=0 except last cycle; hrdata = selected bank slice of sram_q in last cycle.
  - ERR1: hresp=1, hready_out=0, no SRAM access -> ERR2. ERR2: hresp=1, hready_out=1; accepts next transfer.
- hrdata: bank slice of sram_q in RD final cycle, else last read value held.
- Illegal: hsize>LB, address not aligned to hsize, or haddr[31:ADDR_W]!=0.

## Timing
- Writes: zero wait; SRAM written at end of data-phase cycle.
- Reads: RD_WAIT wait states; RD_WAIT=0 gives zero-wait, sram_q sampled same cycle as csn.
- Write then read same address back-to-back: read sees new data (write completes at edge before read access).
- Errors: exactly two data-phase cycles.
- hrstn low at any point, including mid-RD or ERR1: all outputs to reset values next evaluation, state IDLE, in-flight transfer dropped.

## Configuration
- AHB_SRAM_ERR_EN defined: illegal-transfer checks and ERR1/ERR2 present.
- Undefined: no checks; haddr[31:ADDR_W] ignored, hsize>LB treated as full-width, misalignment forced by masking low bits; hresp tied 0.

## Structure
- Package ahb_sram_pkg: htrans codes, hsize codes, OKAY/ERROR, FSM state encoding.
- Sub-module ahb_sram_lane_dec: (hsize, addr[LB-1:0]) -> LANES-bit active-low lane mask.

## Test plan
Config DATA_W=32, ADDR_W=16, NBANK=2, RD_WAIT=1, AHB_SRAM_ERR_EN defined.
- Word write 0x1234 data 0xDEADBEEF -> bank_csn=8'hF0, sram_addr=0x48D, we=1, hready_out=1.
- Byte write 0x8003 -> bank_csn=8'h7F (bank1 lane3); halfword read 0x0002 -> bank_csn=8'hF3, one cycle hready_out=0, hrdata = bank0 q.
- Write 0x0010 then read 0x0010 back-to-back -> hrdata equals written data.
- Halfword at 0x0001 or any access at 0x0001_0000 -> hresp=1 two cycles, hready_out 0 then 1, bank_csn all 1.
- hrstn low during RD wait cycle -> hready_out=1, hresp=0, bank_csn=8'hFF, we=0; next read completes normally.
- IDLE/BUSY with hsel=1 -> no csn activity, hready_out=1, hresp=0.

Source files
------------

// File: rtl/ahb_sram_pkg.sv
// Shared AHB encodings and controller state type for the SRAM controller.
package ahb_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    // A transfer carries an address phase only for NONSEQ and SEQ.
    function automatic logic trans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_sram_lane_dec.sv
// Byte-lane decoder: turns (size, low address bits) into an active-low lane mask.
// Callers guarantee size <= LB and an address aligned to the size.
module ahb_sram_lane_dec #(
    parameter int LANES = 4,
    parameter int LB    = 2
)(
    input  logic [2:0]       hsize_i,
    input  logic [LB-1:0]    addr_i,
    output logic [LANES-1:0] lane_n_o
);
    localparam int CW = LB + 2;

    logic [CW-1:0] first;
    logic [CW-1:0] span;

    assign first = CW'(addr_i);
    assign span  = CW'(1) << hsize_i;

    // A lane is enabled when it falls inside [first, first + span).
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_n_o[gi] = !((CW'(gi) >= first) && (CW'(gi) < first + span));
    end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave in front of a multi-bank, byte-laned single-port SRAM.
// Optional feature macro AHB_SRAM_ERR_EN: when defined, illegal transfers
// (oversize, misaligned, out of range) get a two-cycle ERROR response;
// when undefined they are coerced into legal accesses and hresp stays OKAY.
module ahb_sram_ctrl
    import ahb_sram_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int NBANK   = 2,
    parameter int RD_WAIT = 0,
    localparam int LANES  = DATA_W / 8,
    localparam int LB     = $clog2(LANES),
    localparam int BB     = $clog2(NBANK),
    localparam int SA_W   = ADDR_W - BB - LB
)(
    input  logic                      hclk,
    input  logic                      hrstn,
    input  logic                      hsel,
    input  logic                      hready_in,
    input  logic [1:0]                htrans,
    input  logic [2:0]                hsize,
    input  logic [2:0]                hburst,
    input  logic                      hwrite,
    input  logic [31:0]               haddr,
    input  logic [DATA_W-1:0]         hwdata,
    output logic                      hready_out,
    output logic                      hresp,
    output logic [DATA_W-1:0]         hrdata,
    output logic [NBANK*LANES-1:0]    bank_csn,
    output logic                      sram_we,
    output logic [SA_W-1:0]           sram_addr,
    output logic [DATA_W-1:0]         sram_wdata,
    input  logic [NBANK*LANES*8-1:0]  sram_q
);
    localparam int BW = (BB > 0) ? BB : 1;

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [2:0]          size_q;
    logic [DATA_W-1:0]   hrdata_q;

    logic                accept, illegal, take, csn_act, rd_last;
    logic [2:0]          size_eff;
    logic [ADDR_W-1:0]   addr_eff;
    logic [BW-1:0]       bank_sel;
    logic [LANES-1:0]    lane_n;
    logic [DATA_W-1:0]   bank_q [NBANK];
    logic [DATA_W-1:0]   rd_slice;
    logic                unused_inputs;

    // Bursts are handled beat by beat; hburst carries no information here.
    assign unused_inputs = ^{hburst, haddr};

    assign accept = hsel && hready_in && trans_active(htrans);

    // Clamp size to the bus width and force alignment; a no-op for legal transfers.
    assign size_eff = (hsize > 3'(LB)) ? 3'(LB) : hsize;
    assign addr_eff = haddr[ADDR_W-1:0] & ~ADDR_W'((32'd1 << size_eff) - 32'd1);

`ifdef AHB_SRAM_ERR_EN
    logic misalign;
    assign misalign = |(haddr[2:0] & ~(3'b111 << hsize));
    assign illegal  = (hsize > 3'(LB)) || misalign || ((haddr >> ADDR_W) != 32'd0);
`else
    assign illegal  = 1'b0;
`endif

    // State, wait counter and the registered address phase.
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 2'd0;
            addr_q   <= '0;
            size_q   <= 3'd0;
            hrdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (take && accept) begin
                addr_q <= addr_eff;
                size_q <= size_eff;
            end
            if (rd_last) begin
                hrdata_q <= rd_slice;
            end
        end
    end

    // Data-phase outputs and next state; take marks a cycle that can accept.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hready_out = 1'b1;
        hresp      = HRESP_OKAY;
        sram_we    = 1'b0;
        csn_act    = 1'b0;
        rd_last    = 1'b0;
        take       = 1'b0;
        case (state_q)
            ST_IDLE: take = 1'b1;
            ST_WR: begin
                csn_act = 1'b1;
                sram_we = 1'b1;
                take    = 1'b1;
            end
            ST_RD: begin
                csn_act = 1'b1;
                if (cnt_q == 2'(RD_WAIT)) begin
                    rd_last = 1'b1;
                    take    = 1'b1;
                end else begin
                    hready_out = 1'b0;
                    cnt_d      = cnt_q + 2'd1;
                end
            end
`ifdef AHB_SRAM_ERR_EN
            ST_ERR1: begin
                hresp      = HRESP_ERROR;
                hready_out = 1'b0;
                state_d    = ST_ERR2;
            end
            ST_ERR2: begin
                hresp = HRESP_ERROR;
                take  = 1'b1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        if (take) begin
            cnt_d = 2'd0;
            if (!accept) begin
                state_d = ST_IDLE;
            end else if (illegal) begin
                state_d = ST_ERR1;
            end else if (hwrite) begin
                state_d = ST_WR;
            end else begin
                state_d = ST_RD;
            end
        end
    end

    if (BB > 0) begin : g_bank
        assign bank_sel = addr_q[ADDR_W-1 -: BW];
    end else begin : g_one_bank
        assign bank_sel = '0;
    end

    ahb_sram_lane_dec #(
        .LANES (LANES),
        .LB    (LB)
    ) u_lane_dec (
        .hsize_i  (size_q),
        .addr_i   (addr_q[LB-1:0]),
        .lane_n_o (lane_n)
    );

    for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank_io
        assign bank_csn[gi*LANES +: LANES] = (csn_act && (bank_sel == BW'(gi))) ? lane_n : '1;
        assign bank_q[gi] = sram_q[gi*DATA_W +: DATA_W];
    end

    assign rd_slice   = bank_q[bank_sel];
    assign hrdata     = rd_last ? rd_slice : hrdata_q;
    assign sram_addr  = addr_q[ADDR_W-BB-1:LB];
    assign sram_wdata = hwdata;

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Randomised bench for ahb_sram_ctrl against a byte-addressed memory model.
module tb_ahb_sram_ctrl;
    import ahb_sram_pkg::*;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 16;
    localparam int NBANK   = 2;
    localparam int RD_WAIT = 1;
    localparam int SA_W    = 13;
    localparam int MEMB    = 1 << ADDR_W;
`ifdef AHB_SRAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam int K_WR  = 0;
    localparam int K_RD  = 1;
    localparam int K_ERR = 2;

    logic        hclk = 1'b0;
    logic        hrstn, hsel, hready_in, hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [31:0] haddr, hwdata;
    logic        hready_out, hresp, sram_we;
    logic [31:0] hrdata, sram_wdata;
    logic [7:0]  bank_csn;
    logic [SA_W-1:0] sram_addr;
    logic [63:0] sram_q;

    int errors = 0;
    int checks = 0;
    bit init_req;

    always #5 hclk = ~hclk;
    assign hready_in = hready_out;

    ahb_sram_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NBANK(NBANK), .RD_WAIT(RD_WAIT)
    ) dut (
        .hclk(hclk), .hrstn(hrstn), .hsel(hsel), .hready_in(hready_in),
        .htrans(htrans), .hsize(hsize), .hburst(hburst), .hwrite(hwrite),
        .haddr(haddr), .hwdata(hwdata), .hready_out(hready_out), .hresp(hresp),
        .hrdata(hrdata), .bank_csn(bank_csn), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_q(sram_q)
    );

    function automatic logic [7:0] pat(input int a);
        return 8'((a * 37) ^ ((a >> 5) * 13) ^ 8'h5A);
    endfunction

    // ---------------- SRAM macros: one-cycle read latency, byte writes ----------------
    logic [31:0] sw [MEMB/4];
    logic [31:0] sq [NBANK];
    assign sram_q = {sq[1], sq[0]};

    always @(posedge hclk) begin
        if (init_req) begin
            for (int i = 0; i < MEMB/4; i++)
                sw[i] <= {pat(4*i+3), pat(4*i+2), pat(4*i+1), pat(4*i)};
            for (int b = 0; b < NBANK; b++) sq[b] <= 32'd0;
        end else begin
            for (int b = 0; b < NBANK; b++) begin
                if (bank_csn[b*4 +: 4] != 4'hF) begin
                    if (sram_we) begin
                        for (int l = 0; l < 4; l++)
                            if (!bank_csn[b*4+l])
                                sw[b*(1<<SA_W) + int'(sram_addr)][8*l +: 8] <= sram_wdata[8*l +: 8];
                    end else begin
                        sq[b] <= sw[b*(1<<SA_W) + int'(sram_addr)];
                    end
                end
            end
        end
    end

    // ---------------- Behavioural reference model ----------------
    logic [7:0]  ref_mem [MEMB];
    logic        m_act;
    int          m_kind, m_cyc, m_len, m_size;
    logic [15:0] m_addr;
    logic [31:0] m_last_rd;

    function automatic bit is_illegal(input logic [2:0] sz, input logic [31:0] a);
        if (!ERR_EN) return 1'b0;
        return (sz > 3'd2) || ((a & ((32'd1 << sz) - 32'd1)) != 32'd0) || (a[31:16] != 16'd0);
    endfunction

    function automatic int eff_size(input logic [2:0] sz);
        return (sz > 3'd2) ? 2 : int'(sz);
    endfunction

    function automatic logic [15:0] eff_addr(input logic [31:0] a, input logic [2:0] sz);
        return a[15:0] & ~16'((1 << eff_size(sz)) - 1);
    endfunction

    function automatic int kind_of(input logic w, input logic [2:0] sz, input logic [31:0] a);
        if (is_illegal(sz, a)) return K_ERR;
        return w ? K_WR : K_RD;
    endfunction

    function automatic int len_of(input int k);
        if (k == K_ERR) return 2;
        if (k == K_WR) return 1;
        return RD_WAIT + 1;
    endfunction

    function automatic logic [31:0] ref_word(input logic [15:0] a);
        int w;
        w = int'({a[15:2], 2'b00});
        return {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
    endfunction

    function automatic logic [7:0] exp_csn(input logic [15:0] a, input int sz);
        int nb;
        nb = 1 << sz;
        return ~8'(((1 << nb) - 1) << (4 * int'(a[15]) + int'(a[1:0])));
    endfunction

    always @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            m_act <= 1'b0; m_kind <= 0; m_cyc <= 0; m_len <= 0; m_size <= 0;
            m_addr <= 16'd0; m_last_rd <= 32'd0;
            if (init_req)
                for (int i = 0; i < MEMB; i++) ref_mem[i] <= pat(i);
        end else begin
            if (m_act && m_cyc == m_len - 1 && m_kind == K_WR)
                for (int b = 0; b < (1 << m_size); b++)
                    ref_mem[int'(m_addr) + b] <= hwdata[8*((int'(m_addr) + b) % 4) +: 8];
            if (m_act && m_cyc == m_len - 1 && m_kind == K_RD)
                m_last_rd <= ref_word(m_addr);
            if (!m_act || m_cyc == m_len - 1) begin
                if (hsel && htrans[1]) begin
                    m_act  <= 1'b1;
                    m_cyc  <= 0;
                    m_kind <= kind_of(hwrite, hsize, haddr);
                    m_len  <= len_of(kind_of(hwrite, hsize, haddr));
                    m_size <= eff_size(hsize);
                    m_addr <= eff_addr(haddr, hsize);
                end else begin
                    m_act <= 1'b0;
                end
            end else begin
                m_cyc <= m_cyc + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- Per-cycle compare against the model ----------------
    initial begin
        forever begin
            @(negedge hclk);
            if (!m_act) begin
                chk("idle_ready", 64'(hready_out), 64'd1);
                chk("idle_resp", 64'(hresp), 64'd0);
                chk("idle_csn", 64'(bank_csn), 64'hFF);
                chk("idle_we", 64'(sram_we), 64'd0);
                chk("held_rdata", 64'(hrdata), 64'(m_last_rd));
            end else if (m_kind == K_WR) begin
                chk("wr_csn", 64'(bank_csn), 64'(exp_csn(m_addr, m_size)));
                chk("wr_we", 64'(sram_we), 64'd1);
                chk("wr_ready", 64'(hready_out), 64'd1);
                chk("wr_resp", 64'(hresp), 64'd0);
                chk("wr_addr", 64'(sram_addr), 64'(m_addr[14:2]));
                chk("wr_wdata", 64'(sram_wdata), 64'(hwdata));
            end else if (m_kind == K_RD) begin
                chk("rd_csn", 64'(bank_csn), 64'(exp_csn(m_addr, m_size)));
                chk("rd_we", 64'(sram_we), 64'd0);
                chk("rd_ready", 64'(hready_out), 64'(m_cyc == m_len - 1));
                chk("rd_resp", 64'(hresp), 64'd0);
                chk("rd_addr", 64'(sram_addr), 64'(m_addr[14:2]));
                if (m_cyc == m_len - 1) chk("rd_data", 64'(hrdata), 64'(ref_word(m_addr)));
                else                    chk("rd_wait_data", 64'(hrdata), 64'(m_last_rd));
            end else begin
                chk("err_resp", 64'(hresp), 64'd1);
                chk("err_ready", 64'(hready_out), 64'(m_cyc == 1));
                chk("err_csn", 64'(bank_csn), 64'hFF);
                chk("err_we", 64'(sram_we), 64'd0);
            end
        end
    end

    // Drive one address phase (called at posedge+1) and hold it until accepted.
    task automatic issue(input bit v, input bit w, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        bit rdy;
        int n;
        hsel   = v ? 1'b1 : 1'($urandom % 2);
        htrans = v ? ((($urandom % 2) == 0) ? HTRANS_NONSEQ : HTRANS_SEQ)
                   : ((($urandom % 2) == 0) ? HTRANS_IDLE : HTRANS_BUSY);
        hwrite = w; hsize = sz; haddr = a; hburst = 3'($urandom);
        rdy = 1'b0; n = 0;
        while (!rdy && n < 8) begin
            @(negedge hclk);
            rdy = hready_out;
            @(posedge hclk);
            #1;
            n++;
        end
        chk("accept_bound", 64'(rdy), 64'd1);
        if (v) $display("xfer %s size=%0d addr=%h wdata=%h", w ? "WR" : "RD", sz, a, d);
        else   $display("xfer idle sel=%0d trans=%0d", hsel, htrans);
        htrans = HTRANS_IDLE;
        hwdata = w ? d : 32'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- Stimulus ----------------
    initial begin
        bit v, w;
        logic [2:0] sz;
        logic [31:0] a;
        hrstn = 1'b0; init_req = 1'b1;
        hsel = 1'b0; htrans = HTRANS_IDLE; hsize = HSIZE_WORD; hburst = 3'd0;
        hwrite = 1'b0; haddr = 32'd0; hwdata = 32'd0;
        repeat (3) @(posedge hclk);
        #1;
        init_req = 1'b0;
        chk("rst_ready", 64'(hready_out), 64'd1);
        chk("rst_resp", 64'(hresp), 64'd0);
        chk("rst_csn", 64'(bank_csn), 64'hFF);
        chk("rst_rdata", 64'(hrdata), 64'd0);
        chk("rst_addr", 64'(sram_addr), 64'd0);
        @(negedge hclk);
        hrstn = 1'b1;
        @(posedge hclk);
        #1;

        // Word write 0x1234
        issue(1, 1, HSIZE_WORD, 32'h1234, 32'hDEADBEEF);
        @(negedge hclk);
        chk("pin_w1234_csn", 64'(bank_csn), 64'hF0);
        chk("pin_w1234_addr", 64'(sram_addr), 64'h48D);
        chk("pin_w1234_we", 64'(sram_we), 64'd1);
        chk("pin_w1234_ready", 64'(hready_out), 64'd1);
        @(posedge hclk); #1;

        // Byte write 0x8003, then word 0 seeded, then halfword read 0x0002
        issue(1, 1, HSIZE_BYTE, 32'h8003, 32'h11223344);
        @(negedge hclk);
        chk("pin_b8003_csn", 64'(bank_csn), 64'h7F);
        @(posedge hclk); #1;
        issue(1, 1, HSIZE_WORD, 32'h0000, 32'hA5A55A5A);
        issue(1, 0, HSIZE_HALF, 32'h0002, 32'h0);
        @(negedge hclk);
        chk("pin_h0002_csn", 64'(bank_csn), 64'hF3);
        chk("pin_h0002_wait", 64'(hready_out), 64'd0);
        @(negedge hclk);
        chk("pin_h0002_ready", 64'(hready_out), 64'd1);
        chk("pin_h0002_data", 64'(hrdata), 64'hA5A55A5A);
        @(posedge hclk); #1;

        // Back-to-back write then read of 0x0010
        issue(1, 1, HSIZE_WORD, 32'h0010, 32'hCAFEF00D);
        issue(1, 0, HSIZE_WORD, 32'h0010, 32'h0);
        @(negedge hclk);
        @(negedge hclk);
        chk("pin_wr_rd_data", 64'(hrdata), 64'hCAFEF00D);
        @(posedge hclk); #1;

`ifdef AHB_SRAM_ERR_EN
        issue(1, 0, HSIZE_HALF, 32'h0000_0001, 32'h0);
        @(negedge hclk);
        chk("pin_err1_resp", 64'(hresp), 64'd1);
        chk("pin_err1_ready", 64'(hready_out), 64'd0);
        chk("pin_err1_csn", 64'(bank_csn), 64'hFF);
        @(negedge hclk);
        chk("pin_err2_resp", 64'(hresp), 64'd1);
        chk("pin_err2_ready", 64'(hready_out), 64'd1);
        @(posedge hclk); #1;
        issue(1, 1, HSIZE_WORD, 32'h0001_0000, 32'h12345678);
        @(negedge hclk);
        chk("pin_oor_resp", 64'(hresp), 64'd1);
        chk("pin_oor_csn", 64'(bank_csn), 64'hFF);
        @(posedge hclk); #1;
`endif

        // Reset during the read wait cycle
        issue(1, 0, HSIZE_WORD, 32'h0010, 32'h0);
        #3;
        hrstn = 1'b0;
        #1;
        chk("pin_rst_ready", 64'(hready_out), 64'd1);
        chk("pin_rst_resp", 64'(hresp), 64'd0);
        chk("pin_rst_csn", 64'(bank_csn), 64'hFF);
        chk("pin_rst_we", 64'(sram_we), 64'd0);
        chk("pin_rst_rdata", 64'(hrdata), 64'd0);
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        hrstn = 1'b1;
        @(posedge hclk); #1;
        issue(1, 0, HSIZE_WORD, 32'h0010, 32'h0);
        @(negedge hclk);
        @(negedge hclk);
        chk("pin_after_rst_data", 64'(hrdata), 64'hCAFEF00D);
        @(posedge hclk); #1;

        // BUSY with hsel high: nothing accepted
        hsel = 1'b1; htrans = HTRANS_BUSY; haddr = 32'h1234; hwrite = 1'b1;
        @(negedge hclk);
        chk("pin_busy_csn", 64'(bank_csn), 64'hFF);
        @(posedge hclk); #1;
        htrans = HTRANS_IDLE;
        @(negedge hclk);
        chk("pin_idle_csn", 64'(bank_csn), 64'hFF);
        chk("pin_idle_ready", 64'(hready_out), 64'd1);
        @(posedge hclk); #1;

        // Random traffic
        for (int t = 0; t < 400; t++) begin
            v  = ($urandom % 8) != 0;
            w  = 1'($urandom % 2);
            sz = (($urandom % 16) < 12) ? 3'($urandom % 3) : 3'($urandom % 8);
            if (($urandom % 4) == 0) a = 32'($urandom % 65536);
            else a = {16'h0, 1'($urandom % 2), 9'h0, 6'($urandom % 64)};
            if (($urandom % 8) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            if (($urandom % 32) == 0) a[31:16] = 16'($urandom_range(1, 65535));
            issue(v, w, sz, a, $urandom);
        end
        repeat (3) issue(0, 0, HSIZE_WORD, 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
